up16_fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined processor, directly upstream of decode. It owns the PC, issues one read per cycle to the synchronous 18-bit instruction memory, and loads the IF/ID pipeline register. It absorbs decode stalls with a one-entry skid register and flushes in-flight fetches on EX-stage branch/jump redirects.

---
 rtl/up16_pkg.sv | 22 ++
 rtl/up16_fetch_stage_if.sv | 22 ++
 rtl/up16_if_skid.sv | 36 +++
 rtl/up16_fetch_stage.sv | 148 ++++++++++++++
 tb/tb_up16_fetch_stage.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/up16_pkg.sv
// Shared definitions for the up16 pipeline front end.
// Fetch and decode both import this, so widths and the bubble encoding stay in one place.
package up16_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 18;

    localparam logic [PC_W-1:0]   RESET_PC = 16'h0000;
    localparam logic [INST_W-1:0] NOP_INST = 18'h00000;

    // RUN: normal streaming. HOLD: decode stalled while the skid holds a returned word.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    // Sequential next fetch address; wraps 16'hFFFF to 16'h0000.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/up16_fetch_stage_if.sv
// Instruction memory read port between the fetch stage and the synchronous imem.
// Read data is valid the cycle after imem_en is sampled high.
interface up16_fetch_stage_if;
    import up16_pkg::*;

    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_data
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_data
    );

endinterface

// File: rtl/up16_if_skid.sv
// Single-entry skid register for the fetch stage.
// Catches the instruction word that returns from imem while decode is stalled,
// so it can be handed to IF/ID once the stall releases.
module up16_if_skid
    import up16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              capture,
    input  logic              drain,
    input  logic [INST_W-1:0] load_inst,
    input  logic [PC_W-1:0]   load_pc,
    output logic              held_valid,
    output logic [INST_W-1:0] held_inst,
    output logic [PC_W-1:0]   held_pc
);

    // Flush wins over capture, capture over drain; payload only changes on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= 1'b0;
            held_inst  <= NOP_INST;
            held_pc    <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (capture) begin
            held_valid <= 1'b1;
            held_inst  <= load_inst;
            held_pc    <= load_pc;
        end else if (drain) begin
            held_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/up16_fetch_stage.sv
// Instruction fetch stage of the up16 pipeline.
// Owns the PC, issues one imem read per cycle, loads IF/ID, absorbs decode
// stalls through a one-entry skid and flushes in-flight work on EX redirects.
module up16_fetch_stage
    import up16_pkg::*;
(
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    up16_fetch_stage_if.master         imem,
    output logic [INST_W-1:0]          IF_inst,
    output logic [PC_W-1:0]            IF_pc,
    output logic                       IF_valid,
    output logic [PC_W-1:0]            IF_currPC
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;

    logic [PC_W-1:0]   fetch_pc;
    logic              pend_v;
    logic [PC_W-1:0]   pend_pc;

    logic              skid_v;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;

    logic              issue;
    logic              skid_flush;
    logic              skid_capture;
    logic              skid_drain;
    logic              ifid_flush;
    logic              ifid_load;
    logic              ifid_from_skid;

    // A read goes out whenever decode is not stalled and no redirect is pending;
    // gating with Rst drops the strobe the moment reset asserts.
    assign issue          = Rst & ~stall & ~redirect;
    assign imem.imem_en   = issue;
    assign imem.imem_addr = fetch_pc;
    assign IF_currPC      = fetch_pc;

    // PC and in-flight request tracking; a redirect discards whatever is in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fetch_pc <= RESET_PC;
            pend_v   <= 1'b0;
            pend_pc  <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            pend_v   <= 1'b0;
        end else if (issue) begin
            pend_v   <= 1'b1;
            pend_pc  <= fetch_pc;
            fetch_pc <= pc_next(fetch_pc);
        end else begin
            pend_v   <= 1'b0;
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and IF/ID / skid controls; redirect overrides stall, stall overrides streaming.
    always_comb begin
        state_d        = state_q;
        skid_flush     = 1'b0;
        skid_capture   = 1'b0;
        skid_drain     = 1'b0;
        ifid_flush     = 1'b0;
        ifid_load      = 1'b0;
        ifid_from_skid = 1'b0;
        if (redirect) begin
            skid_flush = 1'b1;
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (stall) begin
                        if (pend_v) begin
                            skid_capture = 1'b1;
                            state_d      = HOLD;
                        end
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_load      = 1'b1;
                        ifid_from_skid = 1'b1;
                        skid_drain     = 1'b1;
                        state_d        = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    up16_if_skid u_skid (
        .clk        (Clk),
        .rst_n      (Rst),
        .flush      (skid_flush),
        .capture    (skid_capture),
        .drain      (skid_drain),
        .load_inst  (imem.imem_data),
        .load_pc    (pend_pc),
        .held_valid (skid_v),
        .held_inst  (skid_inst),
        .held_pc    (skid_pc)
    );

    // IF/ID register: bubble on flush, otherwise load from skid, imem or a bubble.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            IF_inst  <= NOP_INST;
            IF_pc    <= '0;
            IF_valid <= 1'b0;
        end else if (ifid_flush) begin
            IF_inst  <= NOP_INST;
            IF_valid <= 1'b0;
        end else if (ifid_load) begin
            if (ifid_from_skid) begin
                IF_inst  <= skid_inst;
                IF_pc    <= skid_pc;
                IF_valid <= skid_v;
            end else if (pend_v) begin
                IF_inst  <= imem.imem_data;
                IF_pc    <= pend_pc;
                IF_valid <= 1'b1;
            end else begin
                IF_inst  <= NOP_INST;
                IF_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_up16_fetch_stage.sv
// Directed bench for up16_fetch_stage.
// The imem model returns 18'h100 + address, so every valid IF/ID word is predictable from its PC.
module tb_up16_fetch_stage;
    import up16_pkg::*;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              stall = 1'b0;
    logic              redirect = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic [INST_W-1:0] IF_inst;
    logic [PC_W-1:0]   IF_pc;
    logic              IF_valid;
    logic [PC_W-1:0]   IF_currPC;

    int checks = 0;
    int errors = 0;

    up16_fetch_stage_if imem_bus ();

    up16_fetch_stage dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus.master),
        .IF_inst     (IF_inst),
        .IF_pc       (IF_pc),
        .IF_valid    (IF_valid),
        .IF_currPC   (IF_currPC)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 Clk = ~Clk;

    // Synchronous instruction memory model: data for an address the cycle after the strobe.
    always @(posedge Clk) begin
        if (imem_bus.imem_en) begin
            imem_bus.imem_data <= 18'h00100 + {2'b00, imem_bus.imem_addr};
        end
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic r, input logic [PC_W-1:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // IF/ID must hold the real instruction fetched from pc.
    task automatic check_stream(input string tag, input logic [PC_W-1:0] pc);
        logic [INST_W-1:0] exp_inst;
        exp_inst = 18'h00100 + {2'b00, pc};
        check_output({tag, "_valid"}, 32'(IF_valid), 32'd1);
        check_output({tag, "_pc"},    32'(IF_pc),    32'(pc));
        check_output({tag, "_inst"},  32'(IF_inst),  32'(exp_inst));
    endtask

    task automatic check_bubble(input string tag);
        check_output({tag, "_valid"}, 32'(IF_valid), 32'd0);
        check_output({tag, "_inst"},  32'(IF_inst),  32'(NOP_INST));
    endtask

    initial begin
        // Reset held: everything at reset values, no read strobe.
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        check_output("rst_valid", 32'(IF_valid), 32'd0);
        check_output("rst_inst",  32'(IF_inst),  32'(NOP_INST));
        check_output("rst_pc",    32'(IF_pc),    32'd0);
        check_output("rst_en",    32'(imem_bus.imem_en), 32'd0);
        check_output("rst_curr",  32'(IF_currPC), 32'(RESET_PC));

        // Release reset: RESET_PC issued in cycle 0, visible in IF/ID after E1.
        Rst = 1'b1;
        #1;
        check_output("c0_en",   32'(imem_bus.imem_en),   32'd1);
        check_output("c0_addr", 32'(imem_bus.imem_addr), 32'h0000);
        tick();
        check_bubble("e0");
        for (int i = 0; i < 4; i++) begin
            tick();
            check_stream("run", 16'(i));
        end

        // One-cycle stall while IF_pc=3: hold, skid capture, then 4,5,6 with no gap.
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        #1;
        check_output("st1_en", 32'(imem_bus.imem_en), 32'd0);
        tick();
        check_stream("st1_hold", 16'h0003);
        check_output("st1_state", 32'(dut.state_q), 32'(HOLD));
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        for (int i = 4; i <= 6; i++) begin
            tick();
            check_stream("st1_resume", 16'(i));
        end

        // Five-cycle stall: no reads, IF/ID holds pc 6, then 7,8,9.
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_output("st5_en", 32'(imem_bus.imem_en), 32'd0);
            tick();
            check_stream("st5_hold", 16'h0006);
        end
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        for (int i = 7; i <= 9; i++) begin
            tick();
            check_stream("st5_resume", 16'(i));
        end

        // Redirect to 0x0040 while stalled with pc 10 sitting in the skid.
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        tick();
        check_output("rd_state_hold", 32'(dut.state_q), 32'(HOLD));
        apply_stimulus(1'b1, 1'b1, 16'h0040);
        #1;
        check_output("rd_en", 32'(imem_bus.imem_en), 32'd0);
        tick();
        check_bubble("rd_b0");
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        #1;
        check_output("rd_addr", 32'(imem_bus.imem_addr), 32'h0040);
        check_output("rd_curr", 32'(IF_currPC), 32'h0040);
        tick();
        check_bubble("rd_b1");
        tick();
        check_stream("rd_tgt", 16'h0040);
        tick();
        check_stream("rd_next", 16'h0041);

        // PC wrap: redirect to 0xFFFE and free-run across the top of the address space.
        apply_stimulus(1'b0, 1'b1, 16'hFFFE);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick();
        check_bubble("wr_b1");
        tick();
        check_stream("wr_fffe", 16'hFFFE);
        tick();
        check_stream("wr_ffff", 16'hFFFF);
        tick();
        check_stream("wr_0000", 16'h0000);

        // Reset pulsed mid-stream while stalled: immediate clear, then 2-cycle restart.
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        tick();
        #2;
        Rst = 1'b0;
        #1;
        check_output("mr_valid", 32'(IF_valid), 32'd0);
        check_output("mr_inst",  32'(IF_inst),  32'(NOP_INST));
        check_output("mr_pc",    32'(IF_pc),    32'd0);
        check_output("mr_en",    32'(imem_bus.imem_en), 32'd0);
        check_output("mr_curr",  32'(IF_currPC), 32'(RESET_PC));
        check_output("mr_state", 32'(dut.state_q), 32'(RUN));
        tick();
        Rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        #1;
        check_output("mr_c0_en",   32'(imem_bus.imem_en),   32'd1);
        check_output("mr_c0_addr", 32'(imem_bus.imem_addr), 32'(RESET_PC));
        tick();
        check_bubble("mr_e0");
        tick();
        check_stream("mr_e1", 16'h0000);
        tick();
        check_stream("mr_e2", 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
